// File: rtl/therm_pkg.sv
// Shared types, widths and the binary-to-count code map for the thermometer encoder.
package therm_pkg;

    localparam int THERM_W = 16;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } therm_state_e;

    // Codes 0..14 light code+1 elements; code 15 means "all elements off".
    function automatic logic [CNT_W-1:0] bin_to_count(input logic [CNT_W-1:0] bin);
        return (bin == {CNT_W{1'b1}}) ? '0 : bin + CNT_W'(1);
    endfunction

endpackage

// File: rtl/therm_code_gen_if.sv
// Code-request / thermometer-drive bundle between a code source and therm_code_gen.
//
// Handshake: a code transfers on a rising edge where bin_valid and bin_ready are
// both high. The source must hold bin_in stable and bin_valid high until that edge;
// the sink never takes a code while bin_ready is low.
interface therm_code_gen_if;
    import therm_pkg::*;

    logic [CNT_W-1:0]   bin_in;
    logic               bin_valid;
    logic               bin_ready;
    logic [THERM_W-1:0] therm_out;
    logic               done;
    logic               busy;

    modport master (
        output bin_in, bin_valid,
        input  bin_ready, therm_out, done, busy
    );

    modport slave (
        input  bin_in, bin_valid,
        output bin_ready, therm_out, done, busy
    );
endinterface

// File: rtl/therm_shaper.sv
// Maps an asserted-element count and a rotation pointer to a 16-bit element pattern.
// Element i is on when its distance past ptr (mod 16) is below count, so with ptr=0
// this is the plain thermometer (1<<count)-1.
module therm_shaper
    import therm_pkg::*;
(
    input  logic [CNT_W-1:0]   count,
    input  logic [CNT_W-1:0]   ptr,
    output logic [THERM_W-1:0] pattern
);

    // Per-element window test; the 4-bit subtraction wraps to give the modulo.
    always_comb begin
        pattern = '0;
        for (int i = 0; i < THERM_W; i++) begin
            pattern[i] = (CNT_W'(i) - ptr) < count;
        end
    end

endmodule

// File: rtl/therm_code_gen.sv
// Binary-to-thermometer encoder with slew limiting for the unit-element DAC.
// Build option THERM_DWA_EN: rotate the lit elements (data-weighted averaging)
// by advancing a pointer past the elements used by each settled code.
module therm_code_gen
    import therm_pkg::*;
#(
    parameter int STEP_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    therm_code_gen_if.slave  bus,
    output therm_state_e     dbg_state
);

    localparam logic [CNT_W-1:0] STEP_L = CNT_W'(STEP_MAX);

    therm_state_e       state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic [THERM_W-1:0] therm_q, therm_d;
    logic               live_q;
    logic [CNT_W-1:0]   delta;
    logic [CNT_W-1:0]   step;
    logic [THERM_W-1:0] shaped;

    // The pattern uses the pointer as it stood during the ramp; the pointer only
    // moves on DONE entry, so the settled output keeps the elements it ramped with.
    therm_shaper u_shaper (
        .count   (count_d),
        .ptr     (ptr_q),
        .pattern (shaped)
    );

    // Distance to target and the slew-limited step for this edge.
    always_comb begin
        delta = (target_q >= count_q) ? (target_q - count_q) : (count_q - target_q);
        step  = (delta > STEP_L) ? STEP_L : delta;
    end

    // Next-state logic: accept in IDLE, ramp count toward target, one DONE cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        ptr_d    = ptr_q;
        therm_d  = therm_q;
        case (state_q)
            IDLE: begin
                if (bus.bin_valid && live_q) begin
                    target_d = bin_to_count(bus.bin_in);
                    state_d  = RAMP;
                end
            end
            RAMP: begin
                count_d = (target_q >= count_q) ? (count_q + step) : (count_q - step);
                therm_d = shaped;
                if (count_d == target_q) begin
                    state_d = DONE;
`ifdef THERM_DWA_EN
                    ptr_d   = ptr_q + target_q;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; live_q keeps bin_ready low until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            ptr_q    <= '0;
            therm_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            ptr_q    <= ptr_d;
            therm_q  <= therm_d;
            live_q   <= 1'b1;
        end
    end

    assign bus.bin_ready = live_q && (state_q == IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.therm_out = therm_q;
    assign dbg_state     = state_q;

endmodule
